// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared PE definitions: sequencer state encoding and
//               scratchpad geometry constants.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int SPAD_DEPTH = 16;
    localparam int SPAD_AW    = 4;
    localparam int DATA_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COMP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ifmap_spad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifmap_spad_ctrl
// Description : Ifmap scratchpad sequencer. Loads len elements from the
//               upstream stream, then replays 1-D convolution windows of
//               length S with a configurable stride to the MAC datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module ifmap_spad_ctrl #(
    parameter int DATA_W = pe_pkg::DATA_W,
    parameter int DEPTH  = pe_pkg::SPAD_DEPTH,
    parameter int ADDR_W = pe_pkg::SPAD_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4:0]        cfg_len,
    input  logic [4:0]        cfg_filt,
    input  logic [1:0]        cfg_stride,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              spad_rd,
    output logic              spad_wr,
    output logic [ADDR_W-1:0] spad_addr,
    output logic [DATA_W-1:0] spad_wdata,
    input  logic [DATA_W-1:0] spad_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import pe_pkg::*;

    state_t            state;
    state_t            state_nxt;

    // Latched job configuration
    logic [4:0]        len_q;
    logic [4:0]        filt_q;
    logic [2:0]        stride_q;   // actual stride, 1..4

    // Sequencing counters
    logic [ADDR_W-1:0] wptr;
    logic [5:0]        base;       // 6 bits so base+stride+S never wraps
    logic [ADDR_W-1:0] s_cnt;

    logic              cfg_bad;
    logic              start_ok;
    logic              start_bad;
    logic              load_beat;
    logic              load_last;
    logic              issue;
    logic              s_end;
    logic [5:0]        win_end;
    logic              last_win;
    logic              final_issue;
    logic              drain_done;
    logic [ADDR_W-1:0] rd_addr;

    assign cfg_bad    = (cfg_len == 5'd0) || (cfg_len > 5'(DEPTH)) ||
                        (cfg_filt == 5'd0) || (cfg_filt > cfg_len);
    assign start_ok   = (state == IDLE) && start && !cfg_bad;
    assign start_bad  = (state == IDLE) && start && cfg_bad;

    assign load_beat  = (state == LOAD) && in_valid;
    assign load_last  = load_beat && ({1'b0, wptr} == (len_q - 5'd1));

    // A read may be issued whenever the output register is empty or draining
    assign issue      = (state == COMP) && (!out_valid || out_ready);
    assign s_end      = ({1'b0, s_cnt} == (filt_q - 5'd1));
    assign win_end    = base + {3'b000, stride_q} + {1'b0, filt_q};
    assign last_win   = (win_end > {1'b0, len_q});
    assign final_issue = issue && s_end && last_win;
    assign drain_done = (state == DRAIN) && out_valid && out_ready;

    // base+s is always below len, so the low bits are the full address
    assign rd_addr    = base[ADDR_W-1:0] + s_cnt;

    // The scratchpad read port is registered, so its data is the output data
    assign out_data   = spad_rdata;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)    state_nxt = LOAD;
            LOAD:    if (load_last)   state_nxt = COMP;
            COMP:    if (final_issue) state_nxt = DRAIN;
            DRAIN:   if (drain_done)  state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Scratchpad and handshake outputs decoded from state and handshakes
    always_comb begin
        in_ready   = 1'b0;
        spad_wr    = 1'b0;
        spad_rd    = 1'b0;
        spad_addr  = '0;
        spad_wdata = in_data;
        busy       = (state != IDLE);
        case (state)
            LOAD: begin
                in_ready  = 1'b1;
                spad_wr   = load_beat;
                spad_addr = wptr;
            end
            COMP: begin
                spad_rd   = issue;
                spad_addr = rd_addr;
            end
            default: begin
                spad_addr = '0;
            end
        endcase
    end

    // Latch the configuration on an accepted start; pulse err on a rejected one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            filt_q   <= '0;
            stride_q <= '0;
            err      <= 1'b0;
        end else begin
            err <= start_bad;
            if (start_ok) begin
                len_q    <= cfg_len;
                filt_q   <= cfg_filt;
                stride_q <= {1'b0, cfg_stride} + 3'd1;
            end
        end
    end

    // Write pointer and window counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            base  <= '0;
            s_cnt <= '0;
        end else if (start_ok) begin
            wptr  <= '0;
            base  <= '0;
            s_cnt <= '0;
        end else begin
            if (load_beat) begin
                wptr <= wptr + 1'b1;
            end
            if (issue) begin
                if (s_end) begin
                    s_cnt <= '0;
                    base  <= base + {3'b000, stride_q};
                end else begin
                    s_cnt <= s_cnt + 1'b1;
                end
            end
        end
    end

    // Output valid/last track the read data returning one cycle after issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= drain_done;
            if (issue) begin
                out_valid <= 1'b1;
                out_last  <= s_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifmap_spad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifmap_spad_ctrl
// Description : Scoreboard bench for ifmap_spad_ctrl with a behavioural
//               synchronous-read scratchpad.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifmap_spad_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start = 1'b0;
    logic [4:0] cfg_len = '0;
    logic [4:0] cfg_filt = '0;
    logic [1:0] cfg_stride = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       spad_rd;
    logic       spad_wr;
    logic [3:0] spad_addr;
    logic [7:0] spad_wdata;
    logic [7:0] spad_rdata = '0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       done;
    logic       err;

    ifmap_spad_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_len    (cfg_len),
        .cfg_filt   (cfg_filt),
        .cfg_stride (cfg_stride),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .spad_rd    (spad_rd),
        .spad_wr    (spad_wr),
        .spad_addr  (spad_addr),
        .spad_wdata (spad_wdata),
        .spad_rdata (spad_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Scratchpad model: synchronous write, registered read
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (spad_wr) mem[spad_addr] <= spad_wdata;
        if (spad_rd) spad_rdata <= mem[spad_addr];
    end

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       fin;
    } exp_t;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int rdy_mode = 0;
    int ph = 0;

    logic [7:0] ld [16];
    logic [7:0] ex [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_idle(input string name);
        chk(name, {20'd0, in_ready, spad_rd, spad_wr, spad_addr, out_valid,
                   out_last, busy, done, err}, 32'd0);
    endtask

    task automatic set_ld(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) ld[i] = v[8*(n-1-i) +: 8];
    endtask

    task automatic set_ex(input logic [255:0] v, input int n);
        for (int i = 0; i < n; i++) ex[i] = v[8*(n-1-i) +: 8];
    endtask

    // Push expectations, start the job, then stream the ifmap in
    task automatic issue_job(input logic [4:0] len, input logic [4:0] filt,
                             input logic [1:0] strd, input int gap, input int nwin);
        int   f;
        int   g;
        logic acc;
        exp_t e;
        wr_t  w;
        f = int'(filt);
        for (int i = 0; i < int'(len); i++) begin
            w.a = 4'(i);
            w.d = ld[i];
            wr_q.push_back(w);
        end
        for (int k = 0; k < nwin * f; k++) begin
            e.d    = ex[k];
            e.last = ((k % f) == (f - 1));
            e.fin  = (k == (nwin * f - 1));
            exp_q.push_back(e);
        end
        rd_cnt = 0;
        @(posedge clk); #1;
        start      = 1'b1;
        cfg_len    = len;
        cfg_filt   = filt;
        cfg_stride = strd;
        @(posedge clk); #1;
        start      = 1'b0;
        cfg_len    = 5'd1;
        cfg_filt   = 5'd1;
        cfg_stride = 2'd3;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < int'(len); i++) begin
            in_valid = 1'b1;
            in_data  = ld[i];
            g   = 0;
            acc = 1'b0;
            while (!acc && g < 50) begin
                @(negedge clk);
                acc = in_ready;
                g++;
            end
            if (!acc) chk("load_timeout", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (gap != 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(input int exp_rd);
        int   g;
        logic got;
        g   = 0;
        got = 1'b0;
        while (!got && g < 600) begin
            @(negedge clk);
            got = done;
            g++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("rd_count", rd_cnt, exp_rd);
    endtask

    // out_ready pattern driver: always high, or 1,0,0 repeating
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) begin
                out_ready = 1'b1;
                ph = 0;
            end else begin
                out_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
        end
    end

    // Monitor: scoreboard pops, write checks, stall hold and done timing
    logic       pend_done = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = '0;
    logic       stall_last = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_done  = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (pend_done || done) chk("done_pulse", {31'd0, done}, {31'd0, pend_done});
            pend_done = 1'b0;
            if (spad_wr) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", {31'd0, spad_wr}, 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", {28'd0, spad_addr}, {28'd0, w.a});
                    chk("wr_data", {24'd0, spad_wdata}, {24'd0, w.d});
                end
            end
            if (spad_rd) rd_cnt++;
            if (stall_prev) begin
                chk("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, stall_data});
                chk("stall_last", {31'd0, out_last}, {31'd0, stall_last});
            end
            if (out_valid && !out_ready) begin
                chk("rd_while_stalled", {31'd0, spad_rd}, 32'd0);
                stall_prev = 1'b1;
                stall_data = out_data;
                stall_last = out_last;
            end else begin
                stall_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", {24'd0, out_data}, {24'd0, e.d});
                    chk("out_last", {31'd0, out_last}, {31'd0, e.last});
                    pend_done = e.fin;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        #1;
        chk_idle("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic replay: len 5, S 3, stride 1
        set_ld(128'h01_02_03_04_05, 5);
        set_ex(256'h01_02_03_02_03_04_03_04_05, 9);
        issue_job(5'd5, 5'd3, 2'd0, 0, 3);
        wait_done(9);

        // Stride 2 with an ignored start while busy
        set_ld(128'h0A_0B_0C_0D_0E_0F_10, 7);
        set_ex(256'h0A_0B_0C_0C_0D_0E_0E_0F_10, 9);
        issue_job(5'd7, 5'd3, 2'd1, 0, 3);
        @(posedge clk); #1;
        start    = 1'b1;
        cfg_len  = 5'd2;
        cfg_filt = 5'd1;
        @(posedge clk); #1;
        start    = 1'b0;
        wait_done(9);

        // Backpressure on the basic case
        rdy_mode = 1;
        set_ld(128'h01_02_03_04_05, 5);
        set_ex(256'h01_02_03_02_03_04_03_04_05, 9);
        issue_job(5'd5, 5'd3, 2'd0, 0, 3);
        wait_done(9);
        rdy_mode = 0;

        // Full depth, single window, gapped input
        set_ld(128'hA0_A1_A2_A3_A4_A5_A6_A7_A8_A9_AA_AB_AC_AD_AE_AF, 16);
        set_ex(256'hA0_A1_A2_A3_A4_A5_A6_A7_A8_A9_AA_AB_AC_AD_AE_AF, 16);
        issue_job(5'd16, 5'd16, 2'd0, 1, 1);
        wait_done(16);

        // Rejected configs: S > len, and len = 0
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            start    = 1'b1;
            cfg_len  = (t == 0) ? 5'd4 : 5'd0;
            cfg_filt = (t == 0) ? 5'd6 : 5'd1;
            @(posedge clk); #1;
            start    = 1'b0;
            @(negedge clk);
            chk("err_pulse", {30'd0, err, busy}, 32'd2);
            repeat (3) begin
                @(negedge clk);
                chk("err_after", {29'd0, err, busy, spad_wr}, 32'd0);
            end
        end

        // Mid-job reset during COMP
        rdy_mode = 1;
        set_ld(128'h15_16_17_18_19, 5);
        set_ex(256'h15_16_17_16_17_18_17_18_19, 9);
        issue_job(5'd5, 5'd3, 2'd0, 0, 3);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("midjob_reset");
        exp_q.delete();
        wr_q.delete();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reload after reset: len 5, S 2, stride 3
        set_ld(128'h15_16_17_18_19, 5);
        set_ex(256'h15_16_18_19, 4);
        issue_job(5'd5, 5'd2, 2'd2, 0, 2);
        wait_done(4);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifmap_spad_ctrl.md
Name: ifmap_spad_ctrl

Overview:
Sequencer for the PE's 16-entry x 8-bit ifmap scratchpad. The scratchpad has a synchronous read: data appears one cycle after rd. On a start pulse the block first fills the scratchpad from an upstream valid/ready ifmap stream. It then replays 1-D convolution windows (filter length S, configurable stride) to the PE MAC datapath over a valid/ready output stream. It sits between the PE input FIFO and the MAC, and drives the scratchpad's rd/wr/addr/data_in pins directly.

Parameters:
DATA_W, 8, ifmap element width; matches the scratchpad data width
DEPTH, 16, scratchpad entries
ADDR_W, 4, scratchpad address width; equals log2(DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous and active-low
start  in  1  single-cycle job start; sampled only in IDLE
cfg_len  in  5  ifmap elements to load; legal range 1..16
cfg_filt  in  5  filter length S; legal range 1..16
cfg_stride  in  2  window stride minus 1 (0 means stride 1, 3 means stride 4)
in_valid  in  1  upstream ifmap beat valid
in_data  in  DATA_W  upstream ifmap data
in_ready  out  1  block accepts an ifmap beat
spad_rd  out  1  scratchpad read enable
spad_wr  out  1  scratchpad write enable
spad_addr  out  ADDR_W  scratchpad address
spad_wdata  out  DATA_W  scratchpad write data
spad_rdata  in  DATA_W  scratchpad registered read data
out_valid  out  1  window element valid
out_data  out  DATA_W  window element; wired directly to spad_rdata
out_last  out  1  marks the last element of a window
out_ready  in  1  MAC accepts the element
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the job completes
err  out  1  one-cycle pulse when a config is rejected

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE. The following outputs and registers are 0: in_ready, spad_rd, spad_wr, spad_addr, out_valid, out_last, busy, done, err, and all counters.
- Config latching: cfg_* are latched on an accepted start. Config changes during a job are ignored. A start pulse while busy is ignored.
- Config check at start: the config is rejected if len=0, len>16, S=0 or S>len. On rejection:
  - err pulses on the next cycle;
  - done does not pulse;
  - the state stays IDLE and the scratchpad is not touched.
- States: IDLE -> LOAD -> COMP -> DRAIN -> IDLE.
- LOAD:
  - in_ready=1.
  - On each in_valid & in_ready: spad_wr=1, spad_addr=wptr, spad_wdata=in_data, wptr++. This is combinational from the handshake.
  - When the beat with wptr=len-1 is accepted, go to COMP on the next cycle; in_ready is 0 from then on.
- COMP:
  - Counters: base (window start) and s (offset 0..S-1). Both are 0 on entry.
  - Read issue: spad_rd=1 when (!out_valid | out_ready), with spad_addr=base+s.
  - On each issue, advance the counters:
    - if s<S-1, then s++;
    - otherwise s=0 and base+=stride.
  - Window count: the window at base is the last one if base+stride+S > len. Use 6-bit arithmetic so there is no wrap.
  - After the final read of the last window is issued, go to DRAIN.
- Output timing:
  - out_valid is set the cycle after any issued read.
  - out_valid is cleared when out_ready & out_valid and no read is issued that cycle.
  - out_last is registered alongside out_valid; it is 1 when the issuing s was S-1.
  - spad_rdata stays stable while no read is issued, so a stalled output holds its data with no skid buffer. With out_ready held high, throughput is 1 element per cycle.
- DRAIN: wait for the final out_valid & out_ready, then go to IDLE and pulse done in that same cycle.
- Windows per job: floor((len-S)/stride)+1, each S elements long. Address base+s is always less than len, so it fits in 4 bits.
- Mid-job reset: outputs return to their reset values immediately. Scratchpad contents are undefined afterwards, and the next job must reload.

Decomposition:
- Shared package pe_pkg holds:
  - state enum IDLE/LOAD/COMP/DRAIN;
  - constants SPAD_DEPTH=16, SPAD_AW=4, DATA_W=8.
- No sub-module: counter logic is small and stays inline.
- The top PE instantiates this block next to the scratchpad instance.

Test Plan:
- Basic window replay: len=5, S=3, stride=1, load 1,2,3,4,5, out_ready=1 -> out_data 1,2,3, 2,3,4, 3,4,5; out_last on every 3rd element; done pulses one cycle after the final beat is accepted; 9 spad_rd pulses in total.
- Stride 2: len=7, S=3, stride=2 (cfg_stride=1), data 10..16 -> windows 10,11,12 / 12,13,14 / 14,15,16, then done.
- Backpressure: repeat the basic case with out_ready toggling 1,0,0,1,... -> same sequence; out_data stable while stalled; no spad_rd while out_valid & !out_ready.
- Input gaps and full depth: len=16, S=16, in_valid gapped -> writes to addresses 0..15 in order; exactly one window of all 16 values with out_last on the 16th.
- Config rejects and busy start:
  - S=6, len=4 -> err pulse, no spad_wr, busy stays 0.
  - start pulsed during COMP -> ignored, and the current job completes unchanged.
- Mid-job reset: rst_n dropped mid-COMP -> all outputs 0 asynchronously. A new job then reloads and produces correct windows.
